fussgaenger_ampel: RTL

Pedestrian-side controller paired with the vehicle traffic light. It debounces the pedestrian push-button and latches one request. It waits for the vehicle light to show red and asks the vehicle side to hold red, then runs the pedestrian green and clearance phases before releasing the hold. It sits between the button and lamp pins on one side and the vehicle light's `ampelfarbe` output on the other. It is the responder to the vehicle light's red phase.

---
 rtl/ampel_pkg.sv | 74 +++++++
 rtl/knopf_entpreller.sv | 63 ++++++
 rtl/fussgaenger_ampel.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ampel_pkg.sv
// Shared definitions for the pedestrian controller and the vehicle light:
// colour encoding, pedestrian FSM states and the lamp/handshake output bundle.
package ampel_pkg;

    // Vehicle light colour encoding; only FARBE_ROT counts as "vehicle red".
    localparam logic [1:0] FARBE_GRUEN   = 2'b00;
    localparam logic [1:0] FARBE_GELB    = 2'b01;
    localparam logic [1:0] FARBE_ROT     = 2'b10;
    localparam logic [1:0] FARBE_ROTGELB = 2'b11;

    // Pedestrian-side FSM states.
    typedef enum logic [2:0] {
        FG_RUHE    = 3'd0,
        FG_WUNSCH  = 3'd1,
        FG_VORLAUF = 3'd2,
        FG_GRUEN   = 3'd3,
        FG_RAEUMEN = 3'd4,
        FG_FEHLER  = 3'd5
    } fg_zustand_t;

    // All registered outputs of the pedestrian controller in one bundle.
    typedef struct packed {
        logic rot_halten;
        logic wunsch_anzeige;
        logic fg_gruen;
        logic fg_rot;
        logic fehler;
    } fg_ausgaenge_t;

    // True only for a solid vehicle red; red-yellow is already "leaving red".
    function automatic logic ist_kfz_rot(input logic [1:0] farbe);
        return farbe == FARBE_ROT;
    endfunction

    // Lamp pattern for each state. Every branch sets exactly one of
    // fg_gruen / fg_rot, so the pedestrian lamps can never be both on or off.
    function automatic fg_ausgaenge_t ausgaenge_fuer(input fg_zustand_t zustand);
        fg_ausgaenge_t a;
        a = '{rot_halten: 1'b0, wunsch_anzeige: 1'b0, fg_gruen: 1'b0,
              fg_rot: 1'b1, fehler: 1'b0};
        case (zustand)
            FG_RUHE: begin
                a.fg_rot = 1'b1;
            end
            FG_WUNSCH: begin
                a.wunsch_anzeige = 1'b1;
            end
            FG_VORLAUF: begin
                a.rot_halten     = 1'b1;
                a.wunsch_anzeige = 1'b1;
            end
            FG_GRUEN: begin
                a.rot_halten = 1'b1;
                a.fg_gruen   = 1'b1;
                a.fg_rot     = 1'b0;
            end
            FG_RAEUMEN: begin
                a.rot_halten = 1'b1;
            end
            default: begin
                // Fault state: keep vehicles stopped and pedestrians on red.
                a.rot_halten = 1'b1;
                a.fehler     = 1'b1;
            end
        endcase
        return a;
    endfunction

    // Larger of two parameter values, used to size shared counters.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/knopf_entpreller.sv
// Push-button front end: two-flop synchroniser followed by a debouncer that
// emits a single-cycle pulse once a press has been stable long enough. The
// release must be equally stable before another press can be reported.
module knopf_entpreller #(
    parameter int ENTPRELL_ZYKLEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic knopf,
    output logic druck
);

    // Counter only needs to reach ENTPRELL_ZYKLEN-1; keep at least one bit.
    localparam int ZW = (ENTPRELL_ZYKLEN > 1) ? $clog2(ENTPRELL_ZYKLEN) : 1;
    localparam logic [ZW-1:0] ZIEL = ZW'(ENTPRELL_ZYKLEN - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          pegel_q, pegel_d;      // accepted (debounced) level
    logic [ZW-1:0] zaehler_q, zaehler_d;  // consecutive cycles differing from pegel
    logic          druck_q, druck_d;

    // Count cycles in which the synchronised level disagrees with the accepted
    // level; any agreeing cycle (a glitch back) restarts the count.
    always_comb begin
        sync1_d   = knopf;
        sync2_d   = sync1_q;
        pegel_d   = pegel_q;
        zaehler_d = zaehler_q;
        druck_d   = 1'b0;
        if (sync2_q != pegel_q) begin
            if (zaehler_q == ZIEL) begin
                pegel_d   = sync2_q;
                zaehler_d = '0;
                druck_d   = sync2_q;   // only a newly accepted press pulses
            end else begin
                zaehler_d = zaehler_q + 1'b1;
            end
        end else begin
            zaehler_d = '0;
        end
    end

    // Synchroniser and debouncer state, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            pegel_q   <= 1'b0;
            zaehler_q <= '0;
            druck_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pegel_q   <= pegel_d;
            zaehler_q <= zaehler_d;
            druck_q   <= druck_d;
        end
    end

    assign druck = druck_q;

endmodule

// File: rtl/fussgaenger_ampel.sv
// Pedestrian-side traffic light controller. Latches one debounced request,
// waits for vehicle red, holds the vehicle side on red while running the
// lead-in, pedestrian green and clearance phases, and traps into a sticky
// fault state if the vehicle light leaves red while it is being held.
module fussgaenger_ampel
    import ampel_pkg::*;
#(
    parameter int ENTPRELL_ZYKLEN = 4,
    parameter int VORLAUF_ZYKLEN  = 2,
    parameter int GRUEN_ZYKLEN    = 8,
    parameter int RAEUM_ZYKLEN    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       knopf,
    input  logic [1:0] ampelfarbe_kfz,
    output logic       rot_halten,
    output logic       wunsch_anzeige,
    output logic       fg_gruen,
    output logic       fg_rot,
    output logic       fehler
);

    // Phase counter sized for the largest timing parameter (at least 1 bit).
    localparam int MAX_ZYKLEN = max2(max2(ENTPRELL_ZYKLEN, VORLAUF_ZYKLEN),
                                     max2(GRUEN_ZYKLEN, RAEUM_ZYKLEN));
    localparam int PW = (MAX_ZYKLEN > 1) ? $clog2(MAX_ZYKLEN) : 1;

    // Each phase loads N-1 on entry and leaves when the counter reads 0,
    // giving exactly N cycles in the phase.
    localparam logic [PW-1:0] LADE_VORLAUF = PW'(VORLAUF_ZYKLEN - 1);
    localparam logic [PW-1:0] LADE_GRUEN   = PW'(GRUEN_ZYKLEN - 1);
    localparam logic [PW-1:0] LADE_RAEUM   = PW'(RAEUM_ZYKLEN - 1);

    logic          druck;
    logic          kfz_rot;
    fg_zustand_t   zustand_q, zustand_d;
    logic [PW-1:0] phase_q, phase_d;
    fg_ausgaenge_t ausg_q, ausg_d;

    knopf_entpreller #(
        .ENTPRELL_ZYKLEN(ENTPRELL_ZYKLEN)
    ) u_entpreller (
        .clk   (clk),
        .rst_n (rst_n),
        .knopf (knopf),
        .druck (druck)
    );

    assign kfz_rot = ist_kfz_rot(ampelfarbe_kfz);

    // State register, phase counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zustand_q <= FG_RUHE;
            phase_q   <= '0;
            ausg_q    <= ausgaenge_fuer(FG_RUHE);
        end else begin
            zustand_q <= zustand_d;
            phase_q   <= phase_d;
            ausg_q    <= ausg_d;
        end
    end

    // Next state and phase counter; the red-hold check outranks phase ends.
    always_comb begin
        zustand_d = zustand_q;
        phase_d   = phase_q;
        case (zustand_q)
            FG_RUHE: begin
                if (druck) begin
                    zustand_d = FG_WUNSCH;
                end
            end
            FG_WUNSCH: begin
                // Extra presses are simply ignored here: one request is latched.
                if (kfz_rot) begin
                    zustand_d = FG_VORLAUF;
                    phase_d   = LADE_VORLAUF;
                end
            end
            FG_VORLAUF: begin
                if (!kfz_rot) begin
                    zustand_d = FG_FEHLER;
                end else if (phase_q == '0) begin
                    zustand_d = FG_GRUEN;
                    phase_d   = LADE_GRUEN;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            FG_GRUEN: begin
                if (!kfz_rot) begin
                    zustand_d = FG_FEHLER;
                end else if (phase_q == '0) begin
                    zustand_d = FG_RAEUMEN;
                    phase_d   = LADE_RAEUM;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            FG_RAEUMEN: begin
                if (!kfz_rot) begin
                    zustand_d = FG_FEHLER;
                end else if (phase_q == '0) begin
                    zustand_d = FG_RUHE;
                    phase_d   = '0;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            default: begin
                // Fault is sticky; an unknown encoding is treated as a fault too.
                zustand_d = FG_FEHLER;
                phase_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so lamps register together with it.
    always_comb begin
        ausg_d = ausgaenge_fuer(zustand_d);
    end

    assign rot_halten     = ausg_q.rot_halten;
    assign wunsch_anzeige = ausg_q.wunsch_anzeige;
    assign fg_gruen       = ausg_q.fg_gruen;
    assign fg_rot         = ausg_q.fg_rot;
    assign fehler         = ausg_q.fehler;

endmodule
